// File: rtl/ed25519_pkg.sv
// Shared Ed25519 field constants, exponent for Fermat inversion, affine-conversion
// FSM states and a single-step canonicalization helper.
package ed25519_pkg;

    localparam logic [254:0] P_MOD    = ~255'd0 - 255'd18;
    localparam logic [254:0] MONT_ONE = 255'h13;
    localparam logic [254:0] E_EXP    = P_MOD - 255'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SQR,
        S_SQR_W,
        S_MUL,
        S_MUL_W,
        S_NEXT,
        S_UNM,
        S_UNM_W,
        S_XM,
        S_XM_W,
        S_YM,
        S_YM_W,
        S_DONE
    } p2a_state_t;

    // Values below 2p become canonical with at most one subtraction.
    function automatic logic [254:0] mod_reduce_once(input logic [255:0] v);
        return (v >= {1'b0, P_MOD}) ? 255'(v - {1'b0, P_MOD}) : v[254:0];
    endfunction

endpackage

// File: rtl/mont_mul.sv
// Montgomery multiplier over p = 2^255-19 with R = 2^255: result = a*b*R^-1 mod p.
// Processes 17 bits of a per clock, 15 clocks per product; registered start/finished handshake.
module mont_mul
    import ed25519_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [254:0] i_a,
    input  logic [254:0] i_b,
    output logic [254:0] o_result,
    output logic         o_finished
);

    localparam int BPC   = 17;
    localparam int BEATS = 15;

    logic         busy;
    logic [3:0]   cnt;
    logic [254:0] a_r;
    logic [254:0] b_r;
    logic [255:0] t_r;
    logic [255:0] t_nxt;
    logic [256:0] s;

    // Radix-2 reduction steps unrolled; t stays below 2p so 257 bits covers t + b + p.
    always_comb begin
        s     = '0;
        t_nxt = t_r;
        for (int i = 0; i < BPC; i++) begin
            s = {1'b0, t_nxt} + (a_r[i] ? {2'b00, b_r} : 257'd0);
            if (s[0]) begin
                s = s + {2'b00, P_MOD};
            end
            t_nxt = s[256:1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy       <= 1'b0;
            cnt        <= '0;
            a_r        <= '0;
            b_r        <= '0;
            t_r        <= '0;
            o_result   <= '0;
            o_finished <= 1'b0;
        end else begin
            o_finished <= 1'b0;
            if (!busy) begin
                if (i_start) begin
                    a_r  <= i_a;
                    b_r  <= i_b;
                    t_r  <= '0;
                    cnt  <= '0;
                    busy <= 1'b1;
                end
            end else begin
                t_r <= t_nxt;
                a_r <= a_r >> BPC;
                if (cnt == 4'(BEATS - 1)) begin
                    busy       <= 1'b0;
                    o_result   <= mod_reduce_once(t_nxt);
                    o_finished <= 1'b1;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/point_to_affine.sv
// Converts a Montgomery-domain projective Ed25519 point to canonical affine x/y and the
// compressed encoding, inverting Z by Fermat. Optional macro: POINT_TO_AFFINE_ZCHECK_EN.
//
// state   | meaning
// S_IDLE  | waiting for i_start
// S_SQR   | issue acc*acc
// S_SQR_W | wait square, then multiply if exponent bit k is set
// S_MUL   | issue acc*z
// S_MUL_W | wait multiply
// S_NEXT  | step to next exponent bit or finish the ladder
// S_UNM   | issue acc*1 to leave Montgomery form (zinv)
// S_XM    | issue x*zinv
// S_YM    | issue y*zinv
// S_DONE  | canonicalize, load outputs, pulse o_finished
module point_to_affine
    import ed25519_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [254:0] i_x,
    input  logic [254:0] i_y,
    input  logic [254:0] i_z,
    output logic [254:0] o_x,
    output logic [254:0] o_y,
    output logic [255:0] o_encoded,
    output logic         o_busy,
    output logic         o_finished
`ifdef POINT_TO_AFFINE_ZCHECK_EN
    ,
    output logic         o_zero_err
`endif
);

    p2a_state_t   state;
    logic [7:0]   k;
    logic [254:0] x_r;
    logic [254:0] y_r;
    logic [254:0] z_r;
    logic [254:0] acc;
    logic [254:0] res_x;
    logic [254:0] res_y;
    logic         mul_start;
    logic [254:0] mul_a;
    logic [254:0] mul_b;
    logic [254:0] mul_res;
    logic         mul_fin;
    logic [254:0] x_can;
    logic [254:0] y_can;
`ifdef POINT_TO_AFFINE_ZCHECK_EN
    logic         z_zero;
`endif

    assign x_can = mod_reduce_once({1'b0, res_x});
    assign y_can = mod_reduce_once({1'b0, res_y});

    mont_mul u_mul (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (mul_start),
        .i_a        (mul_a),
        .i_b        (mul_b),
        .o_result   (mul_res),
        .o_finished (mul_fin)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            k          <= '0;
            x_r        <= '0;
            y_r        <= '0;
            z_r        <= '0;
            acc        <= '0;
            res_x      <= '0;
            res_y      <= '0;
            mul_start  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            o_x        <= '0;
            o_y        <= '0;
            o_encoded  <= '0;
            o_busy     <= 1'b0;
            o_finished <= 1'b0;
`ifdef POINT_TO_AFFINE_ZCHECK_EN
            z_zero     <= 1'b0;
            o_zero_err <= 1'b0;
`endif
        end else begin
            mul_start  <= 1'b0;
            o_finished <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        x_r    <= i_x;
                        y_r    <= i_y;
                        z_r    <= i_z;
                        acc    <= i_z;
                        k      <= 8'd253;
                        o_busy <= 1'b1;
                        state  <= S_SQR;
`ifdef POINT_TO_AFFINE_ZCHECK_EN
                        o_zero_err <= 1'b0;
                        z_zero     <= (i_z == '0);
                        if (i_z == '0) begin
                            res_x <= '0;
                            res_y <= '0;
                            state <= S_DONE;
                        end
`endif
                    end
                end
                S_SQR: begin
                    mul_a     <= acc;
                    mul_b     <= acc;
                    mul_start <= 1'b1;
                    state     <= S_SQR_W;
                end
                S_SQR_W: begin
                    if (mul_fin) begin
                        acc   <= mul_res;
                        state <= E_EXP[k] ? S_MUL : S_NEXT;
                    end
                end
                S_MUL: begin
                    mul_a     <= acc;
                    mul_b     <= z_r;
                    mul_start <= 1'b1;
                    state     <= S_MUL_W;
                end
                S_MUL_W: begin
                    if (mul_fin) begin
                        acc   <= mul_res;
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (k == 8'd0) begin
                        state <= S_UNM;
                    end else begin
                        k     <= k - 8'd1;
                        state <= S_SQR;
                    end
                end
                S_UNM: begin
                    mul_a     <= acc;
                    mul_b     <= 255'd1;
                    mul_start <= 1'b1;
                    state     <= S_UNM_W;
                end
                S_UNM_W: begin
                    if (mul_fin) begin
                        acc   <= mul_res;
                        state <= S_XM;
                    end
                end
                S_XM: begin
                    mul_a     <= x_r;
                    mul_b     <= acc;
                    mul_start <= 1'b1;
                    state     <= S_XM_W;
                end
                S_XM_W: begin
                    if (mul_fin) begin
                        res_x <= mul_res;
                        state <= S_YM;
                    end
                end
                S_YM: begin
                    mul_a     <= y_r;
                    mul_b     <= acc;
                    mul_start <= 1'b1;
                    state     <= S_YM_W;
                end
                S_YM_W: begin
                    if (mul_fin) begin
                        res_y <= mul_res;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_x        <= x_can;
                    o_y        <= y_can;
                    o_encoded  <= {x_can[0], y_can};
                    o_finished <= 1'b1;
                    o_busy     <= 1'b0;
                    state      <= S_IDLE;
`ifdef POINT_TO_AFFINE_ZCHECK_EN
                    o_zero_err <= z_zero;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_point_to_affine.sv
// Scoreboard bench for point_to_affine: directed vectors push expectations, a monitor
// pops and compares on every o_finished. Zero-Z checks build with POINT_TO_AFFINE_ZCHECK_EN.
module tb_point_to_affine;
    import ed25519_pkg::*;

    localparam int LIMIT = 12000;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_start;
    logic [254:0] i_x, i_y, i_z;
    logic [254:0] o_x, o_y;
    logic [255:0] o_encoded;
    logic         o_busy, o_finished;
`ifdef POINT_TO_AFFINE_ZCHECK_EN
    logic         o_zero_err;
`endif

    point_to_affine dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_x        (i_x),
        .i_y        (i_y),
        .i_z        (i_z),
        .o_x        (o_x),
        .o_y        (o_y),
        .o_encoded  (o_encoded),
        .o_busy     (o_busy),
        .o_finished (o_finished)
`ifdef POINT_TO_AFFINE_ZCHECK_EN
        ,
        .o_zero_err (o_zero_err)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [254:0] x;
        logic [254:0] y;
        logic [255:0] enc;
        logic         zerr;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   n_fin = 0;

    localparam logic [255:0] BX_W = 256'h216936D3CD6E53FEC0A4E231FDD6DC5C692CC7609525A7B2C9562D608F25D51A;
    localparam logic [255:0] BY_W = 256'h6666666666666666666666666666666666666666666666666666666666666658;
    localparam logic [254:0] Y_HALF = (255'd1 << 254) - 255'd9;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge i_clk) begin
        if (!i_rst && o_finished === 1'b1) begin
            exp_t e;
            n_fin++;
            chk("finish_expected", 256'(sb.size() != 0), 256'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("o_x", {1'b0, o_x}, {1'b0, e.x});
                chk("o_y", {1'b0, o_y}, {1'b0, e.y});
                chk("o_encoded", o_encoded, e.enc);
`ifdef POINT_TO_AFFINE_ZCHECK_EN
                chk("o_zero_err", 256'(o_zero_err), 256'(e.zerr));
`endif
            end
        end
    end

    task automatic issue(input logic [254:0] x, input logic [254:0] y, input logic [254:0] z,
                         input logic [254:0] ex, input logic [254:0] ey, input logic ez,
                         input logic hold);
        exp_t e;
        e.x = ex;
        e.y = ey;
        e.enc = {ex[0], ey};
        e.zerr = ez;
        sb.push_back(e);
        @(negedge i_clk);
        i_x = x;
        i_y = y;
        i_z = z;
        i_start = 1'b1;
        @(negedge i_clk);
        if (!hold) i_start = 1'b0;
        if (!ez) chk("busy_after_start", 256'(o_busy), 256'd1);
`ifdef POINT_TO_AFFINE_ZCHECK_EN
        if (!ez) chk("zero_err_cleared", 256'(o_zero_err), 256'd0);
`endif
    endtask

    task automatic wait_done(input int limit);
        int i = 0;
        while (o_finished !== 1'b1 && i < limit) begin
            @(negedge i_clk);
            i++;
        end
        chk("done_in_time", 256'(o_finished), 256'd1);
        @(negedge i_clk);
        chk("finish_single_pulse", 256'(o_finished), 256'd0);
        chk("busy_low_after", 256'(o_busy), 256'd0);
    endtask

    initial begin
        logic [511:0] prod;
        logic [511:0] r;
        logic [254:0] xr, yr, bx, by;
        int           f0;

        i_rst = 1'b1;
        i_start = 1'b0;
        i_x = '0;
        i_y = '0;
        i_z = '0;
        repeat (3) @(negedge i_clk);
        chk("rst_o_x", {1'b0, o_x}, 256'd0);
        chk("rst_o_y", {1'b0, o_y}, 256'd0);
        chk("rst_o_encoded", o_encoded, 256'd0);
        chk("rst_o_busy", 256'(o_busy), 256'd0);
        chk("rst_o_finished", 256'(o_finished), 256'd0);
`ifdef POINT_TO_AFFINE_ZCHECK_EN
        chk("rst_o_zero_err", 256'(o_zero_err), 256'd0);
`endif
        i_rst = 1'b0;

        // (2,3,1) in Montgomery form: each times R = 19 mod p
        issue(255'd38, 255'd57, 255'd19, 255'd2, 255'd3, 1'b0, 1'b0);
        wait_done(LIMIT);

        // (2,1,2) -> x = 1, y = 1/2
        issue(255'd38, 255'd19, 255'd38, 255'd1, Y_HALF, 1'b0, 1'b0);
        wait_done(LIMIT);

        // Base point with Z = 1: inputs are (Bx*R, By*R, R)
        bx = BX_W[254:0];
        by = BY_W[254:0];
        prod = {257'd0, bx} * 512'd19;
        r = prod % {257'd0, P_MOD};
        xr = r[254:0];
        prod = {257'd0, by} * 512'd19;
        r = prod % {257'd0, P_MOD};
        yr = r[254:0];
        issue(xr, yr, 255'd19, bx, by, 1'b0, 1'b0);
        wait_done(LIMIT);

        // Start held high during a run: only the first is accepted
        f0 = n_fin;
        issue(255'd57, 255'd38, 255'd19, 255'd3, 255'd2, 1'b0, 1'b1);
        repeat (3000) @(negedge i_clk);
        chk("busy_while_start_held", 256'(o_busy), 256'd1);
        i_start = 1'b0;
        wait_done(LIMIT);
        repeat (40) @(negedge i_clk);
        chk("single_finish_held_start", 256'(n_fin - f0), 256'd1);
        issue(255'd19, 255'd19, 255'd19, 255'd1, 255'd1, 1'b0, 1'b0);
        wait_done(LIMIT);

        // Reset around multiplication #100
        issue(255'd38, 255'd57, 255'd19, 255'd2, 255'd3, 1'b0, 1'b0);
        repeat (1850) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("midrst_o_x", {1'b0, o_x}, 256'd0);
        chk("midrst_o_y", {1'b0, o_y}, 256'd0);
        chk("midrst_o_encoded", o_encoded, 256'd0);
        chk("midrst_o_busy", 256'(o_busy), 256'd0);
        i_rst = 1'b0;
        sb.delete();
        f0 = n_fin;
        repeat (40) @(negedge i_clk);
        chk("no_finish_after_rst", 256'(n_fin - f0), 256'd0);
        issue(255'd57, 255'd38, 255'd19, 255'd3, 255'd2, 1'b0, 1'b0);
        wait_done(LIMIT);

`ifdef POINT_TO_AFFINE_ZCHECK_EN
        issue(255'd38, 255'd57, 255'd0, 255'd0, 255'd0, 1'b1, 1'b0);
        wait_done(3);
        chk("zero_err_held", 256'(o_zero_err), 256'd1);
        issue(255'd38, 255'd57, 255'd19, 255'd2, 255'd3, 1'b0, 1'b0);
        wait_done(LIMIT);
`endif

        chk("scoreboard_drained", 256'(sb.size()), 256'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
